// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the timer array.
// Holds the per-channel FSM state encoding, register offsets, mode codes,
// CTRL bit positions, the CTRL payload struct and its 32-bit read formatter.
package timer_pkg;

    // Per-channel sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    // Field widths
    localparam int unsigned BUS_W  = 32;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned MODE_W = 2;
    localparam int unsigned PSC_W  = 8;

    // Register select codes (addr[3:2]); code 3 is unmapped
    localparam logic [SEL_W-1:0] REG_CTRL   = 2'd0;
    localparam logic [SEL_W-1:0] REG_PRESET = 2'd1;
    localparam logic [SEL_W-1:0] REG_COUNT  = 2'd2;

    // Mode codes; anything other than auto-reload behaves as one-shot
    localparam logic [MODE_W-1:0] MODE_ONESHOT = 2'b00;
    localparam logic [MODE_W-1:0] MODE_RELOAD  = 2'b01;

    // CTRL bit positions
    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_MODE_LSB = 1;
    localparam int unsigned CTRL_IM_BIT   = 3;
    localparam int unsigned CTRL_PEND_BIT = 4;
    localparam int unsigned CTRL_PSC_LSB  = 8;

    // Stored CTRL contents of one channel
    typedef struct packed {
        logic [PSC_W-1:0]  psc;
        logic              pend;
        logic              im;
        logic [MODE_W-1:0] mode;
        logic              en;
    } ctrl_t;

    // Place CTRL fields at their bus positions; unused bits read 0
    function automatic logic [BUS_W-1:0] ctrl_to_word(input ctrl_t c);
        logic [BUS_W-1:0] word;
        word = '0;
        word[CTRL_EN_BIT]                   = c.en;
        word[CTRL_MODE_LSB +: MODE_W]       = c.mode;
        word[CTRL_IM_BIT]                   = c.im;
        word[CTRL_PEND_BIT]                 = c.pend;
        word[CTRL_PSC_LSB +: PSC_W]         = c.psc;
        return word;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// timer_channel: one down-counting timer with prescaler and interrupt pending.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   wr_ctrl, wr_preset  decoded write strobes for this channel
//   wd                  write data
//   ctrl_rd             CTRL formatted for the bus
//   preset_rd, count_rd PRESET / COUNT zero-extended to 32 bits
//   irq                 PEND & IM
module timer_channel
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_ctrl,
    input  logic              wr_preset,
    input  logic [BUS_W-1:0]  wd,
    output logic [BUS_W-1:0]  ctrl_rd,
    output logic [BUS_W-1:0]  preset_rd,
    output logic [BUS_W-1:0]  count_rd,
    output logic              irq
);

    state_t             state_q,   state_d;
    ctrl_t              ctrl_q,    ctrl_d;
    logic [WIDTH-1:0]   preset_q,  preset_d;
    logic [WIDTH-1:0]   count_q,   count_d;
    logic [PSC_W-1:0]   psc_cnt_q, psc_cnt_d;
    logic               pend_set;

    // Upper data bits are only meaningful to PRESET when WIDTH is wide
    logic unused_wd;
    assign unused_wd = ^wd[BUS_W-1:16];

    // State and register file
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ctrl_q    <= '0;
            preset_q  <= '0;
            count_q   <= '0;
            psc_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            psc_cnt_q <= psc_cnt_d;
        end
    end

    // Next-state, counting and register update
    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        preset_d  = preset_q;
        count_d   = count_q;
        psc_cnt_d = psc_cnt_q;
        pend_set  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q.en) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d   = preset_q;
                psc_cnt_d = '0;
                state_d   = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q.en) begin
                    state_d = ST_IDLE;
                end else if (count_q == '0) begin
                    // PEND rises on the edge that enters INT
                    pend_set = 1'b1;
                    state_d  = ST_INT;
                end else if (psc_cnt_q == ctrl_q.psc) begin
                    psc_cnt_d = '0;
                    count_d   = count_q - WIDTH'(1);
                end else begin
                    psc_cnt_d = psc_cnt_q + PSC_W'(1);
                end
            end
            ST_INT: begin
                if (ctrl_q.mode == MODE_RELOAD) begin
                    state_d = ST_LOAD;
                end else begin
                    ctrl_d.en = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // PRESET only takes effect at the next LOAD
        if (wr_preset) begin
            preset_d = wd[WIDTH-1:0];
        end

        // Software CTRL write overrides the hardware EN clear in INT
        if (wr_ctrl) begin
            ctrl_d.en   = wd[CTRL_EN_BIT];
            ctrl_d.mode = wd[CTRL_MODE_LSB +: MODE_W];
            ctrl_d.im   = wd[CTRL_IM_BIT];
            ctrl_d.psc  = wd[CTRL_PSC_LSB +: PSC_W];
            if (wd[CTRL_PEND_BIT]) begin
                ctrl_d.pend = 1'b0;
            end
        end

        // Hardware set beats a same-edge write-1-to-clear
        if (pend_set) begin
            ctrl_d.pend = 1'b1;
        end
    end

    // Read views and interrupt, all from registered state
    assign ctrl_rd   = ctrl_to_word(ctrl_q);
    assign preset_rd = BUS_W'(preset_q);
    assign count_rd  = BUS_W'(count_q);
    assign irq       = ctrl_q.pend & ctrl_q.im;

endmodule

// File: rtl/timer_array.sv
// timer_array: N_CH independent timers behind a simple select/write bus.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   sel, we     block select and write strobe (write when both high)
//   addr        byte address: [5:4] channel, [3:2] register
//   wd          write data
//   rd          read data, combinational from addr
//   irq         per-channel interrupt
module timer_array
    import timer_pkg::*;
#(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic              we,
    input  logic [BUS_W-1:0]  addr,
    input  logic [BUS_W-1:0]  wd,
    output logic [BUS_W-1:0]  rd,
    output logic [N_CH-1:0]   irq
);

    logic [SEL_W-1:0] ch_sel;
    logic [SEL_W-1:0] reg_sel;
    logic             wr_en;

    logic [BUS_W-1:0] ctrl_rd   [N_CH];
    logic [BUS_W-1:0] preset_rd [N_CH];
    logic [BUS_W-1:0] count_rd  [N_CH];

    // Address bits outside the register/channel fields are don't-care
    logic unused_addr;
    assign unused_addr = ^{addr[BUS_W-1:6], addr[1:0]};

    assign ch_sel  = addr[5:4];
    assign reg_sel = addr[3:2];
    assign wr_en   = sel & we;

    // One channel per index; unmatched channel indices decode to nothing
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic hit;
        assign hit = wr_en && (ch_sel == SEL_W'(c));

        timer_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .wr_ctrl   (hit && (reg_sel == REG_CTRL)),
            .wr_preset (hit && (reg_sel == REG_PRESET)),
            .wd        (wd),
            .ctrl_rd   (ctrl_rd[c]),
            .preset_rd (preset_rd[c]),
            .count_rd  (count_rd[c]),
            .irq       (irq[c])
        );
    end

    // Read mux; unmapped offsets and channels read 0
    always_comb begin
        rd = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (ch_sel == SEL_W'(c)) begin
                case (reg_sel)
                    REG_CTRL:   rd = ctrl_rd[c];
                    REG_PRESET: rd = preset_rd[c];
                    REG_COUNT:  rd = count_rd[c];
                    default:    rd = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_array.sv
// tb_timer_array: directed scenarios plus randomized timer runs checked
// against closed-form timing (interrupt at P*(k+1)+3 cycles after enable).
module tb_timer_array;

    logic        clk;
    logic        reset;
    logic        sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [1:0]  irq;

    int vectors;
    int miscompares;

    timer_array #(.N_CH(2), .WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .wd    (wd),
        .rd    (rd),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, return at the following falling edge
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One write; the write lands on the next rising edge
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        sel  = 1'b1;
        we   = 1'b1;
        addr = a;
        wd   = d;
        @(posedge clk);
        @(negedge clk);
        sel  = 1'b0;
        we   = 1'b0;
        wd   = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rd;
    endtask

    task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(a, v);
        check(tag, v, exp);
    endtask

    task automatic check_irq(input string tag, input logic [1:0] exp);
        check(tag, 32'(irq), 32'(exp));
    endtask

    initial begin
        int unsigned ch, p, k, mode, t, dchk, cexp;
        logic [31:0] base, w, rv;

        vectors     = 0;
        miscompares = 0;
        sel   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wd    = '0;
        reset = 1'b1;

        // Reset values visible while reset is held
        #2;
        check_irq("rst_irq", 2'b00);
        check_reg("rst_c0_ctrl",   32'h00, 32'h0);
        check_reg("rst_c0_preset", 32'h04, 32'h0);
        check_reg("rst_c0_count",  32'h08, 32'h0);
        check_reg("rst_c1_ctrl",   32'h10, 32'h0);
        check_reg("rst_c1_preset", 32'h14, 32'h0);
        check_reg("rst_c1_count",  32'h18, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cycle();

        // One-shot, PRESET=3: irq 6 cycles after the enabling write
        bus_write(32'h04, 32'd3);
        bus_write(32'h00, 32'h9);
        repeat (5) cycle();
        check_irq("os_irq_before", 2'b00);
        cycle();
        check_irq("os_irq_at6", 2'b01);
        cycle();
        check_reg("os_ctrl_en_cleared", 32'h00, 32'h18);
        check_reg("os_count_zero",      32'h08, 32'h0);
        bus_write(32'h00, 32'h10);
        check_irq("os_irq_cleared", 2'b00);

        // Prescaler: PRESET=2, PSC=3 -> 11 cycles
        bus_write(32'h04, 32'd2);
        bus_write(32'h00, 32'h309);
        repeat (10) cycle();
        check_irq("psc_irq_before", 2'b00);
        cycle();
        check_irq("psc_irq_at11", 2'b01);
        cycle();
        check_reg("psc_ctrl", 32'h00, 32'h318);
        bus_write(32'h00, 32'h10);

        // Auto-reload on ch1, PRESET=2: PEND every 5 cycles
        bus_write(32'h14, 32'd2);
        bus_write(32'h10, 32'hB);
        repeat (4) cycle();
        check_irq("ar_irq_before", 2'b00);
        cycle();
        check_irq("ar_irq_p1", 2'b10);
        bus_write(32'h10, 32'h1B);
        check_irq("ar_w1c_1", 2'b00);
        repeat (3) cycle();
        check_irq("ar_gap_2", 2'b00);
        cycle();
        check_irq("ar_irq_p2", 2'b10);
        bus_write(32'h10, 32'h1B);
        check_irq("ar_w1c_2", 2'b00);
        repeat (3) cycle();
        check_irq("ar_gap_3", 2'b00);
        // W1C lands on the same edge PEND is set: set wins
        bus_write(32'h10, 32'h1B);
        check_reg("ar_w1c_race_ctrl", 32'h10, 32'h1B);
        check_irq("ar_w1c_race_irq", 2'b10);
        bus_write(32'h10, 32'h10);
        repeat (4) cycle();
        check_reg("ar_disabled_ctrl", 32'h10, 32'h0);
        check_irq("ar_disabled_irq", 2'b00);

        // Reset asserted mid-count on ch0
        bus_write(32'h04, 32'd8);
        bus_write(32'h00, 32'h9);
        repeat (5) cycle();
        check_reg("mid_count5", 32'h08, 32'd5);
        #1;
        reset = 1'b1;
        #1;
        check_irq("mid_rst_irq", 2'b00);
        check_reg("mid_rst_c0_ctrl",   32'h00, 32'h0);
        check_reg("mid_rst_c0_preset", 32'h04, 32'h0);
        check_reg("mid_rst_c0_count",  32'h08, 32'h0);
        check_reg("mid_rst_c1_preset", 32'h14, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) cycle();
        check_irq("post_rst_no_irq", 2'b00);
        check_reg("post_rst_c0_ctrl",  32'h00, 32'h0);
        check_reg("post_rst_c0_count", 32'h08, 32'h0);

        // Ignored writes: channel 2, offset 0xC, COUNT, channel 3
        bus_write(32'h28, 32'hFFFF_FFFF);
        bus_write(32'h0C, 32'hFFFF_FFFF);
        bus_write(32'h08, 32'hFFFF_FFFF);
        bus_write(32'h38, 32'hFFFF_FFFF);
        bus_write(32'h20, 32'hFFFF_FFFF);
        repeat (5) cycle();
        check_reg("unmap_rd_0c", 32'h0C, 32'h0);
        check_reg("unmap_rd_28", 32'h28, 32'h0);
        check_reg("unmap_rd_20", 32'h20, 32'h0);
        check_reg("unmap_c0_ctrl",   32'h00, 32'h0);
        check_reg("unmap_c0_preset", 32'h04, 32'h0);
        check_reg("unmap_c0_count",  32'h08, 32'h0);
        check_reg("unmap_c1_ctrl",   32'h10, 32'h0);
        check_irq("unmap_irq", 2'b00);

        // Randomized runs against closed-form timing
        for (int it = 0; it < 12; it++) begin
            ch   = $urandom_range(1, 0);
            p    = $urandom_range(6, 0);
            k    = $urandom_range(3, 0);
            mode = $urandom_range(3, 0);
            base = 32'(ch) << 4;
            t    = p * (k + 1) + 3;
            dchk = $urandom_range(t - 1, 2);
            w    = (32'(k) << 8) | 32'h8 | (32'(mode) << 1) | 32'h1;

            bus_write(base + 32'h4, 32'(p));
            bus_write(base, w);
            for (int d = 1; d <= int'(t); d++) begin
                cycle();
                if (d == int'(dchk)) begin
                    cexp = p - (dchk - 2) / (k + 1);
                    bus_read(base + 32'h8, rv);
                    check("rnd_count", rv, 32'(cexp));
                end
                check_irq("rnd_irq_first", (d == int'(t)) ? 2'(1 << ch) : 2'b00);
            end

            if (mode == 1) begin
                bus_write(base, w | 32'h10);
                check_irq("rnd_reload_w1c", 2'b00);
                for (int d = int'(t) + 2; d <= 2 * int'(t); d++) begin
                    cycle();
                    check_irq("rnd_irq_reload", (d == 2 * int'(t)) ? 2'(1 << ch) : 2'b00);
                end
                bus_write(base, 32'h10);
                repeat (4) cycle();
                check_reg("rnd_reload_off", base, 32'h0);
            end else begin
                cycle();
                check_reg("rnd_oneshot_ctrl", base, (w & ~32'h1) | 32'h10);
                bus_write(base, 32'h10);
                check_irq("rnd_oneshot_clr", 2'b00);
                repeat (3) cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
